// File: rtl/e203_exu_eai_csr_bridge_pkg.sv
// Shared definitions for the EAI CSR bridge.
// Contents: the data widths, the timeout counter width, the FSM state
// encoding, the latched-request record and the request-compare helper.
package e203_exu_eai_csr_bridge_pkg;

    localparam int E203_XLEN       = 32;
    localparam int E203_CSR_ADDR_W = 12;
    localparam int EAI_TMO_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } eai_state_e;

    // One CSR request, exactly as the requester presents it.
    typedef struct packed {
        logic [E203_CSR_ADDR_W-1:0] addr;
        logic                       wr;
        logic [E203_XLEN-1:0]       wdata;
    } eai_req_t;

    // A retried request is the same request only if every field matches.
    function automatic logic req_match(input eai_req_t a, input eai_req_t b);
        return (a == b);
    endfunction

endpackage

// File: rtl/e203_exu_eai_csr_bridge_if.sv
// Signal bundle between the CSR requester, the bridge and the accelerator's
// CSR bus.
// Modports:
//   slave  - the bridge. It takes eai_csr_* requests and eai_err_clr.
//            It masters the eai_bus_cmd_* channel.
//            It consumes the eai_bus_rsp_* channel.
//   master - the environment: the requester plus the accelerator slave.
interface e203_exu_eai_csr_bridge_if;
    import e203_exu_eai_csr_bridge_pkg::*;

    logic                       eai_csr_valid;
    logic                       eai_csr_ready;
    logic [E203_CSR_ADDR_W-1:0] eai_csr_addr;
    logic                       eai_csr_wr;
    logic [E203_XLEN-1:0]       eai_csr_wdata;
    logic [E203_XLEN-1:0]       eai_csr_rdata;
    logic                       eai_bus_cmd_valid;
    logic                       eai_bus_cmd_ready;
    logic [E203_CSR_ADDR_W-1:0] eai_bus_cmd_addr;
    logic                       eai_bus_cmd_wr;
    logic [E203_XLEN-1:0]       eai_bus_cmd_wdata;
    logic                       eai_bus_rsp_valid;
    logic                       eai_bus_rsp_ready;
    logic [E203_XLEN-1:0]       eai_bus_rsp_rdata;
    logic                       eai_bus_rsp_err;
    logic                       eai_err_sticky;
    logic                       eai_err_clr;

    modport slave (
        input  eai_csr_valid, eai_csr_addr, eai_csr_wr, eai_csr_wdata,
               eai_bus_cmd_ready, eai_bus_rsp_valid, eai_bus_rsp_rdata,
               eai_bus_rsp_err, eai_err_clr,
        output eai_csr_ready, eai_csr_rdata, eai_bus_cmd_valid,
               eai_bus_cmd_addr, eai_bus_cmd_wr, eai_bus_cmd_wdata,
               eai_bus_rsp_ready, eai_err_sticky
    );

    modport master (
        output eai_csr_valid, eai_csr_addr, eai_csr_wr, eai_csr_wdata,
               eai_bus_cmd_ready, eai_bus_rsp_valid, eai_bus_rsp_rdata,
               eai_bus_rsp_err, eai_err_clr,
        input  eai_csr_ready, eai_csr_rdata, eai_bus_cmd_valid,
               eai_bus_cmd_addr, eai_bus_cmd_wr, eai_bus_cmd_wdata,
               eai_bus_rsp_ready, eai_err_sticky
    );

endinterface

// File: rtl/e203_exu_eai_csr_bridge_tmo_cnt.sv
// Response-wait timeout counter for the EAI CSR bridge.
// Ports:
//   clk, rst_n - clock and async active-low reset
//   clr_i      - zero the count (new transaction)
//   en_i       - count this cycle (waiting for a response)
//   hit_o      - the current wait cycle is the TIMEOUT_CYC-th one
module e203_eai_tmo_cnt
    import e203_exu_eai_csr_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [EAI_TMO_CNT_W-1:0] CNT_MAX = {EAI_TMO_CNT_W{1'b1}};
    localparam logic [EAI_TMO_CNT_W-1:0] CNT_ONE = {{(EAI_TMO_CNT_W-1){1'b0}}, 1'b1};
    // The count starts at 0 on the first wait cycle. It therefore equals
    // TIMEOUT_CYC-1 on the TIMEOUT_CYC-th wait cycle. Firing then puts the
    // owner in its next state exactly TIMEOUT_CYC cycles after entry.
    localparam logic [EAI_TMO_CNT_W-1:0] HIT_AT  = EAI_TMO_CNT_W'(TIMEOUT_CYC - 1);

    logic [EAI_TMO_CNT_W-1:0] cnt_q;
    logic [EAI_TMO_CNT_W-1:0] cnt_d;

    // Next count: clear wins; otherwise increment and saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {EAI_TMO_CNT_W{1'b0}};
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {EAI_TMO_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q >= HIT_AT);

endmodule

// File: rtl/e203_exu_eai_csr_bridge.sv
// EAI CSR bridge. It turns the ALU's single-cycle eai_csr_* request into one
// command/response transaction towards the accelerator's CSR bank.
// The result is held until the requester re-presents the same request.
// Faults set a sticky flag: error responses, timeouts and stray responses.
// Ports:
//   clk, rst_n - clock and async active-low reset
//   eai_if     - slave view of e203_exu_eai_csr_bridge_if
//   TIMEOUT_CYC parameter (1..255) - cycles to wait in RSP
module e203_exu_eai_csr_bridge
    import e203_exu_eai_csr_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    e203_exu_eai_csr_bridge_if.slave      eai_if
);

    eai_state_e           state_q, state_d;
    eai_req_t             req_q, req_d, req_in_s;
    logic [E203_XLEN-1:0] rdata_q, rdata_d;
    logic                 cmd_valid_q;
    logic                 rsp_ready_q;
    logic                 sticky_q, sticky_d;
    logic                 err_set_s;
    logic                 cnt_clr_s;
    logic                 tmo_hit_s;
    logic                 rsp_hs_s;
    logic                 req_match_s;

    assign req_in_s    = {eai_if.eai_csr_addr, eai_if.eai_csr_wr, eai_if.eai_csr_wdata};
    assign req_match_s = eai_if.eai_csr_valid & req_match(req_in_s, req_q);
    assign rsp_hs_s    = eai_if.eai_bus_rsp_valid & rsp_ready_q;

    e203_eai_tmo_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_s),
        .en_i  (state_q == ST_RSP),
        .hit_o (tmo_hit_s)
    );

    // FSM next state, request latch, result capture and fault detection.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        cnt_clr_s = 1'b0;
        err_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eai_if.eai_csr_valid) begin
                    req_d     = req_in_s;
                    cnt_clr_s = 1'b1;
                    state_d   = ST_CMD;
                end else begin
                    state_d   = ST_IDLE;
                end
                // A response with nothing outstanding is a late slave.
                err_set_s = rsp_hs_s;
            end
            ST_CMD: begin
                if (eai_if.eai_bus_cmd_ready) begin
                    state_d = ST_RSP;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_RSP: begin
                // A response in the same cycle as the timeout still counts.
                if (rsp_hs_s) begin
                    rdata_d   = eai_if.eai_bus_rsp_err ? {E203_XLEN{1'b0}}
                                                       : eai_if.eai_bus_rsp_rdata;
                    err_set_s = eai_if.eai_bus_rsp_err;
                    state_d   = ST_DONE;
                end else if (tmo_hit_s) begin
                    rdata_d   = {E203_XLEN{1'b0}};
                    err_set_s = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_RSP;
                end
            end
            ST_DONE: begin
                err_set_s = rsp_hs_s;
                if (req_match_s) begin
                    state_d = ST_IDLE;
                end else if (eai_if.eai_csr_valid) begin
                    // A different request: drop the held result and restart.
                    req_d     = req_in_s;
                    cnt_clr_s = 1'b1;
                    state_d   = ST_CMD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky fault flag: a new fault outranks a clear in the same cycle.
    always_comb begin
        sticky_d = sticky_q;
        if (err_set_s) begin
            sticky_d = 1'b1;
        end else if (eai_if.eai_err_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State, latched request, captured data and registered bus handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            rdata_q     <= {E203_XLEN{1'b0}};
            cmd_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            cmd_valid_q <= (state_d == ST_CMD);
            // Responses are accepted everywhere except CMD.
            rsp_ready_q <= (state_d != ST_CMD);
            sticky_q    <= sticky_d;
        end
    end

    assign eai_if.eai_csr_ready     = (state_q == ST_DONE) & req_match_s;
    assign eai_if.eai_csr_rdata     = rdata_q;
    assign eai_if.eai_bus_cmd_valid = cmd_valid_q;
    assign eai_if.eai_bus_cmd_addr  = req_q.addr;
    assign eai_if.eai_bus_cmd_wr    = req_q.wr;
    assign eai_if.eai_bus_cmd_wdata = req_q.wdata;
    assign eai_if.eai_bus_rsp_ready = rsp_ready_q;
    assign eai_if.eai_err_sticky    = sticky_q;

endmodule

// File: doc/e203_exu_eai_csr_bridge.md
# e203_exu_eai_csr_bridge

Sits directly downstream of the ALU CSR controller's EAI port: accepts the single-cycle `eai_csr_*` request (ready-stalls the CSR instruction) and turns it into one multi-cycle transaction on a split command/response bus towards the external accelerator's CSR bank. Only one transaction is outstanding at a time. The block holds the returned read data until the requester takes it, bounds the wait for a response with a timeout, and records faults in a sticky error flag.

## Interface
- `TIMEOUT_CYC`, 255: max cycles waited in RSP before forced completion; range 1..255.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; one clock; asynchronous assert, active-low.
- `eai_csr_valid`  in  1  request valid, already qualified upstream by select, instr-valid and writeback-ready.
- `eai_csr_ready`  out  1  request accepted / rdata valid this cycle.
- `eai_csr_addr`  in  12 (`E203_CSR_ADDR_W`)  CSR index.
- `eai_csr_wr`  in  1  write enable.
- `eai_csr_wdata`  in  `E203_XLEN`  write data.
- `eai_csr_rdata`  out  `E203_XLEN`  read data, meaningful when ready=1.
- `eai_bus_cmd_valid` / `eai_bus_cmd_ready`  out / in  1  command handshake.
- `eai_bus_cmd_addr`  out  12; `eai_bus_cmd_wr`  out  1; `eai_bus_cmd_wdata`  out  `E203_XLEN`.
- `eai_bus_rsp_valid` / `eai_bus_rsp_ready`  in / out  1  response handshake.
- `eai_bus_rsp_rdata`  in  `E203_XLEN`; `eai_bus_rsp_err`  in  1.
- `eai_err_sticky`  out  1  fault seen since last clear.
- `eai_err_clr`  in  1  clears sticky flag.

## Operation
- FSM states and outputs:
  - IDLE: `eai_csr_ready`=0; `eai_bus_rsp_ready`=1.
  - CMD: `eai_bus_cmd_valid`=1, with cmd fields driven from latched registers.
  - RSP: `eai_bus_rsp_ready`=1; timeout counter runs.
  - DONE: `eai_csr_ready`=1 when the match rule below holds; `eai_csr_rdata` comes from the captured register.
- IDLE → CMD on `eai_csr_valid`. Latch addr, wr and wdata. Clear the counter.
- CMD → RSP on `eai_bus_cmd_ready`. The command is never withdrawn: no timeout applies in CMD.
- RSP → DONE on `eai_bus_rsp_valid`:
  - Capture rdata.
  - If `rsp_err`=1: rdata captured as 0 and the sticky flag is set.
- RSP → DONE on timeout, when the counter reaches `TIMEOUT_CYC` with no response: rdata=0, sticky set.
- DONE, match rule: ready=1 only if `eai_csr_valid` and the incoming addr/wr/wdata equal the latched values.
  - Match: handshake completes → IDLE.
  - Valid with mismatch: the held result is discarded, the new request is latched → CMD; ready stays 0.
  - Valid=0: hold indefinitely.
- `eai_csr_valid` dropping during CMD/RSP: the transaction still completes and its side effects stand; the result is held in DONE.
- Response arriving in IDLE/DONE (late slave): accepted (rsp_ready=1) and discarded; sticky set. A response arriving in CMD is a protocol violation and is not checked.
- Sticky flag: a set and `eai_err_clr` in the same cycle → set wins.
- Counter: 8 bits, saturating, counts only in RSP.

## Timing
- Reset values: state IDLE. All outputs 0 (`cmd_valid`, `rsp_ready`, `eai_csr_ready`, `rdata`, `cmd_*`, `err_sticky`). Latched registers and counter are 0.
- Reset mid-transaction returns immediately to IDLE. `cmd_valid` drops asynchronously and the transaction is abandoned.
- Minimum latency, with zero-wait bus (cycle 0 = valid first seen in IDLE):
  - cycle 1: CMD, cmd_valid=1, cmd_ready=1.
  - cycle 2: RSP, rsp_valid=1.
  - cycle 3: DONE, `eai_csr_ready`=1, handshake.
  - cycle 4: IDLE.
- `eai_csr_ready` and `eai_csr_rdata` are pure state/register decodes. The match compare is the only input-dependent term, and there is no combinational path from bus inputs to them.
- Timeout: entering RSP at cycle t with no response → DONE at t+`TIMEOUT_CYC`.

## Structure
- Shared package/defines: FSM state encoding (2-bit; IDLE=0, CMD=1, RSP=2, DONE=3), `E203_XLEN`, `E203_CSR_ADDR_W`, timeout counter width (8).
- Sub-module `e203_eai_tmo_cnt`: saturating counter with clear, enable and `hit` output compared against `TIMEOUT_CYC`.
- Remainder: FSM, request/response capture registers and match comparator in the top module.

## Test plan
- Read, zero-wait bus: addr=0xE01, wr=0, slave returns 0xDEADBEEF → `eai_csr_ready`=1 at cycle 3, rdata=0xDEADBEEF, back to IDLE at cycle 4, sticky=0.
- Write with 5-cycle cmd_ready stall: addr=0xE10, wdata=0x12345678 → cmd fields held stable for 5 cycles, exactly one cmd handshake, ready at cycle 8.
- Timeout with `TIMEOUT_CYC`=4 and no response → DONE 4 cycles after RSP entry, rdata=0, sticky=1. A later stray response in IDLE is consumed and sticky stays 1. `eai_err_clr` then clears it to 0.
- Flush: valid drops in RSP; response 0xA5 arrives; valid returns 3 cycles later with the same request → ready=1 on that cycle with rdata=0xA5, and no second cmd is issued.
- Mismatch in DONE: new request addr=0xE20 arrives → no ready, a new cmd to 0xE20 is issued, and it completes normally.
- Async reset asserted in RSP → all outputs 0 immediately; after release, the next request starts cleanly from IDLE.
